// File: rtl/mul_repeated_add.sv
// Unsigned multiplier by repeated addition: A and B arrive serially on data_in,
// then P accumulates A once per cycle while B counts down to zero.
module mul_repeated_add #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] product,
  output logic             done,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  // Handshake: start is a level request seen only in IDLE; the result on
  // product is valid while done=1, and DONE is held until start drops, so
  // a new operation needs start to go low and then high again.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_ADD    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             eqz;

  assign eqz = (b_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        a_d     = data_in;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        b_d     = data_in;
        p_d     = '0;
        state_d = S_ADD;
      end
      S_ADD: begin
        // B is checked before each add, so B=0 exits without touching P
        if (eqz) begin
          state_d = S_DONE;
        end else begin
          p_d = p_q + a_q;
          b_d = b_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign product   = p_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_ADD);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_repeated_add.sv
// Directed and table-driven bench for mul_repeated_add: operand loading,
// accumulation latency, truncation, DONE hold and asynchronous reset.
module tb_mul_repeated_add;

  localparam int W = 16;
  localparam int MAX_EDGES = 300;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] product;
  logic         done;
  logic         busy;
  logic [2:0]   dbg_state;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_p;
    int           exp_edges;
  } vec_t;

  vec_t vecs[8];

  mul_repeated_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .product   (product),
    .done      (done),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives one operation from IDLE; returns product seen with done and the
  // number of edges after the start-sampling edge at which done appeared.
  // start is left high, so the DUT remains in DONE on return.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] p, output int edges);
    @(negedge clk);
    start   = 1'b1;
    data_in = '0;
    @(posedge clk);
    @(negedge clk);
    data_in = a;
    @(posedge clk);
    @(negedge clk);
    data_in = b;
    @(posedge clk);
    edges = 2;
    @(negedge clk);
    data_in = '0;
    while (!done && edges < MAX_EDGES) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!done) check("op_timeout", 32'(edges), 32'(MAX_EDGES + 1));
    p = product;
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] p;
    int           edges;
    logic [W-1:0] ra, rb;

    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{a: 16'd17,   b: 16'd5,   exp_p: 16'd85,    exp_edges: 8};
    vecs[1] = '{a: 16'd9,    b: 16'd0,   exp_p: 16'd0,     exp_edges: 3};
    vecs[2] = '{a: 16'd0,    b: 16'd3,   exp_p: 16'd0,     exp_edges: 6};
    vecs[3] = '{a: 16'hFFFF, b: 16'd2,   exp_p: 16'hFFFE,  exp_edges: 5};
    vecs[4] = '{a: 16'd7,    b: 16'd6,   exp_p: 16'd42,    exp_edges: 9};
    vecs[5] = '{a: 16'd1,    b: 16'd1,   exp_p: 16'd1,     exp_edges: 4};
    vecs[6] = '{a: 16'd255,  b: 16'd255, exp_p: 16'd65025, exp_edges: 258};
    vecs[7] = '{a: 16'h8000, b: 16'd3,   exp_p: 16'h8000,  exp_edges: 6};

    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    #3;
    check("reset_product", 32'(product), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic: partial sums visible on every ADD edge
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd17;
    check("basic_busy_load_a", 32'(busy), 32'h1);
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd5;
    @(posedge clk);
    @(negedge clk);
    check("basic_p_cleared", 32'(product), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("basic_partial_%0d", k), 32'(product), 32'(17 * k));
      check($sformatf("basic_notdone_%0d", k), 32'(done), 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    check("basic_done", 32'(done), 32'h1);
    check("basic_busy_off", 32'(busy), 32'h0);
    check("basic_product", 32'(product), 32'd85);
    release_start();

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, p, edges);
      check($sformatf("vec%0d_product", i), 32'(p), 32'(vecs[i].exp_p));
      check($sformatf("vec%0d_latency", i), 32'(edges), 32'(vecs[i].exp_edges));
      release_start();
      check($sformatf("vec%0d_idle", i), 32'(dbg_state), 32'h0);
    end

    // DONE holds while start stays high, then a fresh operation
    run_op(16'd5, 16'd5, p, edges);
    check("hold_first_product", 32'(p), 32'd25);
    repeat (3) @(negedge clk);
    check("hold_done", 32'(done), 32'h1);
    check("hold_product", 32'(product), 32'd25);
    release_start();
    check("hold_back_idle_done", 32'(done), 32'h0);
    check("hold_back_idle_busy", 32'(busy), 32'h0);
    run_op(16'd7, 16'd6, p, edges);
    check("b2b_product", 32'(p), 32'd42);
    check("b2b_latency", 32'(edges), 32'd9);
    release_start();

    // asynchronous reset in the middle of the third add
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd4;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'd10;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_add_partial", 32'(product), 32'd8);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("async_rst_product", 32'(product), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_state", 32'(dbg_state), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_state", 32'(dbg_state), 32'h0);
    check("post_rst_idle_busy", 32'(busy), 32'h0);
    run_op(16'd3, 16'd4, p, edges);
    check("post_rst_product", 32'(p), 32'd12);
    release_start();

    // random 8-bit operand pairs
    for (int i = 0; i < 50; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      run_op(ra, rb, p, edges);
      check($sformatf("rand%0d_product a=%0d b=%0d", i, ra, rb), 32'(p),
            (32'(ra) * 32'(rb)) & 32'h0000_FFFF);
      check($sformatf("rand%0d_latency", i), 32'(edges), 32'(rb) + 32'd3);
      release_start();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
